// File: rtl/barrel_unrotator.sv
// Purpose : pipelined inverse barrel rotator; rotates in_data right by (in_amt mod WIDTH), undoing an upstream rotl.
// Latency : STAGES = $clog2(WIDTH) cycles; one log2 shift stage per register, outputs come straight from flops.
// Backpres: out_valid & ~out_ready freezes every stage (no bubble collapsing); in_ready = ~stall & ~rst.
//
// Ports:
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready     input handshake; in_data = rotated word, in_amt = left-rotate amount applied upstream
//   out_valid/out_ready   output handshake; out_data = recovered word, out_amt = in_amt echoed
//   out_wrap              only with BARREL_UNROTATOR_WRAP_FLAG_EN: beat's in_amt was >= WIDTH
//
// Optional feature macro: BARREL_UNROTATOR_WRAP_FLAG_EN
module barrel_unrotator #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
`ifdef BARREL_UNROTATOR_WRAP_FLAG_EN
  output logic [AMT_W-1:0] out_amt,
  output logic             out_wrap
`else
  output logic [AMT_W-1:0] out_amt
`endif
);

  localparam int STAGES = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  // Amount zero-extended so every stage bit and the wrap test are in range even for narrow AMT_W.
  localparam int EXT_W  = AMT_W + STAGES;

  if (WIDTH < 2 || WIDTH > 256 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("barrel_unrotator: WIDTH must be a power of 2 in 2..256");
  end

  typedef struct packed {
    logic             vld;
`ifdef BARREL_UNROTATOR_WRAP_FLAG_EN
    logic             wrap;
`endif
    logic [AMT_W-1:0] amt;
    logic [WIDTH-1:0] dat;
  } stage_t;

  stage_t stg_q [STAGES];
  stage_t stg_d [STAGES];
  stage_t src   [STAGES];  // what each stage would load if the pipe advances
  logic   stall;

  function automatic logic [WIDTH-1:0] rotr_pow2(input logic [WIDTH-1:0] x, input int k);
    return (x >> (1 << k)) | (x << (WIDTH - (1 << k)));
  endfunction

  function automatic logic amt_bit(input logic [AMT_W-1:0] a, input int k);
    logic [EXT_W-1:0] ext;
    ext = EXT_W'(a);
    return ext[k];
  endfunction

  assign stall    = stg_q[STAGES-1].vld & ~out_ready;
  assign in_ready = ~stall & ~rst;

  always_comb begin
    src[0]     = '0;
    src[0].vld = in_valid & in_ready;
    src[0].amt = in_amt;
    src[0].dat = in_data;
`ifdef BARREL_UNROTATOR_WRAP_FLAG_EN
    src[0].wrap = (EXT_W'(in_amt) >> STAGES) != '0;
`endif
    for (int k = 1; k < STAGES; k++) begin
      src[k] = stg_q[k-1];
    end

    for (int k = 0; k < STAGES; k++) begin
      stg_d[k] = stg_q[k];
      if (!stall) begin
        stg_d[k] = src[k];
        // Stage k contributes a 2^k right-rotate when bit k of the amount is set.
        if (amt_bit(src[k].amt, k)) begin
          stg_d[k].dat = rotr_pow2(src[k].dat, k);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        stg_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        stg_q[k] <= stg_d[k];
      end
    end
  end

  assign out_valid = stg_q[STAGES-1].vld;
  assign out_data  = stg_q[STAGES-1].dat;
  assign out_amt   = stg_q[STAGES-1].amt;
`ifdef BARREL_UNROTATOR_WRAP_FLAG_EN
  assign out_wrap  = stg_q[STAGES-1].wrap;
`endif

endmodule

// File: tb/tb_barrel_unrotator.sv
// Bench for barrel_unrotator (WIDTH=32): directed latency, stream, backpressure and
// mid-stream reset cases, then a randomized run against a queue-based reference model.
module tb_barrel_unrotator;
  localparam int W  = 32;
  localparam int AW = 8;
  localparam int ST = $clog2(W);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic [AW-1:0] in_amt = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic [AW-1:0] out_amt;
`ifdef BARREL_UNROTATOR_WRAP_FLAG_EN
  logic          out_wrap;
`endif

  always #5 clk = ~clk;

  barrel_unrotator #(.WIDTH(W), .AMT_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef BARREL_UNROTATOR_WRAP_FLAG_EN
    .out_amt   (out_amt),
    .out_wrap  (out_wrap)
`else
    .out_amt   (out_amt)
`endif
  );

  typedef struct {
    logic [W-1:0]  dat;
    logic [AW-1:0] amt;
    logic          wrap;
  } beat_t;

  beat_t         sbq[$];
  int            n_tests = 0;
  int            n_fail  = 0;
  int            n_acc   = 0;
  int            n_out   = 0;
  int            run_len = 0;
  int            max_run = 0;
  logic          fired, accepted;
  logic          prev_stall = 1'b0;
  logic [W-1:0]  prev_dat;
  logic [AW-1:0] prev_amt;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference rotations: repeated single-bit rotates, amount reduced modulo W.
  function automatic logic [W-1:0] rotr_ref(input logic [W-1:0] x, input int n);
    logic [W-1:0] r = x;
    for (int i = 0; i < n % W; i++) r = {r[0], r[W-1:1]};
    return r;
  endfunction

  function automatic logic [W-1:0] rotl_ref(input logic [W-1:0] x, input int n);
    logic [W-1:0] r = x;
    for (int i = 0; i < n % W; i++) r = {r[W-2:0], r[W-1]};
    return r;
  endfunction

  function automatic beat_t model(input logic [W-1:0] d, input logic [AW-1:0] a);
    beat_t b;
    b.dat  = rotr_ref(d, int'(a));
    b.amt  = a;
    b.wrap = (int'(a) >= W);
    return b;
  endfunction

  // Sampled 2 time units after the rising edge; decides what the next edge transfers.
  task automatic observe();
    beat_t e;
    chk("in_ready_rule", in_ready, !(out_valid && !out_ready));
    if (prev_stall) begin
      chk("hold_vld", out_valid, 1'b1);
      chk("hold_dat", out_data, prev_dat);
      chk("hold_amt", out_amt, prev_amt);
    end
    fired = out_valid && out_ready;
    if (fired) begin
      n_out++;
      run_len++;
      if (run_len > max_run) max_run = run_len;
      if (sbq.size() == 0) begin
        chk("spurious_out", out_valid, 1'b0);
      end else begin
        e = sbq.pop_front();
        chk("out_data", out_data, e.dat);
        chk("out_amt", out_amt, e.amt);
`ifdef BARREL_UNROTATOR_WRAP_FLAG_EN
        chk("out_wrap", out_wrap, e.wrap);
`endif
      end
    end else begin
      run_len = 0;
    end
    accepted = in_valid && in_ready;
    if (accepted) begin
      n_acc++;
      sbq.push_back(model(in_data, in_amt));
    end
    prev_stall = out_valid && !out_ready;
    prev_dat   = out_data;
    prev_amt   = out_amt;
  endtask

  task automatic step(input logic iv, input logic [W-1:0] d, input logic [AW-1:0] a, input logic ordy);
    @(posedge clk);
    #1;
    in_valid  = iv;
    in_data   = d;
    in_amt    = a;
    out_ready = ordy;
    #1;
    observe();
  endtask

  task automatic drain(input int budget);
    int c = 0;
    while (sbq.size() > 0 && c < budget) begin
      step(1'b0, '0, '0, 1'b1);
      c++;
    end
    chk("drain_empty", sbq.size(), 0);
  endtask

  // One beat into an empty pipe; latency counted in edges, accepting edge included.
  task automatic single_beat(input string tag, input logic [W-1:0] d, input logic [AW-1:0] a,
                             input logic [W-1:0] exp_dat);
    int lat = 0;
    step(1'b1, d, a, 1'b1);
    do begin
      step(1'b0, '0, '0, 1'b1);
      lat++;
    end while (!out_valid && lat < 20);
    chk({tag, "_lat"}, lat, ST);
    chk({tag, "_dat"}, out_data, exp_dat);
    chk({tag, "_amt"}, out_amt, a);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0]  base, pd;
    logic [AW-1:0] pa;
    logic          pv;
    int            acc0, out0, cyc;

    // Reset asserted before any clock edge: outputs must clear without a clock.
    #1 rst = 1'b1;
    #2;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, '0);
    chk("rst_out_amt", out_amt, '0);
    chk("rst_in_ready", in_ready, 1'b0);
`ifdef BARREL_UNROTATOR_WRAP_FLAG_EN
    chk("rst_out_wrap", out_wrap, 1'b0);
`endif
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;

    // Directed single beat with known answer.
    single_beat("t1", 32'h3832CD02, 8'd4, 32'h23832CD0);

    // Back-to-back stream amt 0..16, each data pre-rotated left so output is base.
    base    = $urandom;
    max_run = 0;
    acc0    = n_acc;
    for (int a = 0; a <= 16; a++) step(1'b1, rotl_ref(base, a), AW'(a), 1'b1);
    drain(40);
    chk("t2_accepted", n_acc - acc0, 17);
    chk("t2_run", max_run, 17);

    // Wrap-around sweep: multiples of W and W+k.
    for (int a = 28; a <= 40; a++) step(1'b1, rotl_ref(base, a), AW'(a), 1'b1);
    step(1'b1, base, AW'(2 * W), 1'b1);
    step(1'b1, base, AW'(3 * W), 1'b1);
    drain(40);

    // Backpressure: fill the pipe with out_ready low, hold 4 stalled cycles, release.
    acc0 = n_acc;
    out0 = n_out;
    for (int i = 0; i < ST + 1; i++) step(1'b1, $urandom, AW'($urandom_range(0, 255)), 1'b0);
    chk("bp_fill", n_acc - acc0, ST);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, $urandom, AW'($urandom_range(0, 255)), 1'b0);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_out_valid", out_valid, 1'b1);
    end
    chk("bp_no_accept", n_acc - acc0, ST);
    drain(40);
    chk("bp_out_count", n_out - out0, ST);

    // Reset mid-stream with 3 beats in flight, first one stalled at the output.
    step(1'b1, $urandom, 8'd7, 1'b0);
    step(1'b1, $urandom, 8'd9, 1'b0);
    step(1'b1, $urandom, 8'd33, 1'b0);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      step(1'b0, '0, '0, 1'b0);
      cyc++;
    end
    chk("mr_pre_valid", out_valid, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("mr_out_valid", out_valid, 1'b0);
    chk("mr_in_ready", in_ready, 1'b0);
    chk("mr_out_data", out_data, '0);
    sbq.delete();
    prev_stall = 1'b0;
    @(posedge clk);
    #3 rst = 1'b0;
    out0 = n_out;
    for (int i = 0; i < 10; i++) step(1'b0, '0, '0, 1'b1);
    chk("mr_no_stale", n_out - out0, 0);
    base = $urandom;
    single_beat("mr_next", base, 8'd77, rotr_ref(base, 77));

    // Randomized traffic; a pending beat is held until accepted.
    acc0 = n_acc;
    out0 = n_out;
    pv   = 1'b0;
    pd   = '0;
    pa   = '0;
    cyc  = 0;
    while ((n_acc - acc0) < 10000 && cyc < 60000) begin
      if (!pv && $urandom_range(0, 3) != 0) begin
        pv = 1'b1;
        pd = $urandom;
        pa = AW'($urandom_range(0, 255));
      end
      step(pv, pd, pa, $urandom_range(0, 3) != 0);
      if (accepted) pv = 1'b0;
      cyc++;
    end
    drain(100);
    chk("rand_accepted", n_acc - acc0, 10000);
    chk("rand_out_count", n_out - out0, n_acc - acc0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
